// File: rtl/typing_session_engine.sv
// Per-session typing engine: countdown/run/pause phases, typed-word buffer,
// keystroke scoring against the current dictionary word, and display statistics.
module typing_session_engine #(
  parameter int unsigned MAX_LEN     = 15,
  parameter int unsigned CODE_W      = 5,
  parameter int unsigned CNTDN_TICKS = 30,
  parameter int unsigned LIMIT_TICKS = 1800,
  parameter int unsigned STAT_W      = 11,
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk_div,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      pause,
  input  logic                      mode,
  input  logic [6:0]                target,
  input  logic                      key_valid,
  input  logic [CODE_W-1:0]         key_code,
  input  logic                      key_space,
  input  logic                      key_back,
  input  logic [MAX_LEN*CODE_W-1:0] word,
  input  logic [LW-1:0]             word_len,
  output logic                      word_req,
  output logic [2:0]                state,
  output logic [MAX_LEN*CODE_W-1:0] typed,
  output logic [LW-1:0]             cursor,
  output logic [LW-1:0]             correct,
  output logic [6:0]                words_done,
  output logic [STAT_W-1:0]         elapsed,
  output logic [STAT_W-1:0]         remaining,
  output logic [9:0]                wpm,
  output logic [9:0]                acc,
  output logic [6:0]                streak,
  output logic [6:0]                best_streak,
  output logic                      finish
);

  localparam int unsigned CW = $clog2(CNTDN_TICKS + 2);
  localparam int unsigned PW = STAT_W + 7;
  localparam int unsigned GW = STAT_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CNTDN = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      mode_q, mode_d;
  logic [6:0]                target_q, target_d;
  logic [MAX_LEN*CODE_W-1:0] typed_q, typed_d;
  logic [LW-1:0]             cursor_q, cursor_d, correct_q, correct_d;
  logic [6:0]                words_q, words_d, streak_q, streak_d, best_q, best_d;
  logic [STAT_W-1:0]         elapsed_q, elapsed_d, keys_q, keys_d, good_q, good_d;
  logic [9:0]                wpm_q, wpm_d, acc_q, acc_d;
  logic                      req_q, req_d, fin_q, fin_d;

  logic [PW-1:0]     tgt10, rem_w, sum_w, wpm_w, acc_w;
  logic [STAT_W-1:0] rem;
  logic [GW-1:0]     good_sum;
  logic [CODE_W-1:0] exp_char;
  logic [6:0]        streak_n;
  logic              fin_cond, full_word, go_idle, do_start;

  function automatic logic [6:0] inc7(input logic [6:0] v);
    return (v == '1) ? v : v + 7'd1;
  endfunction

  always_comb begin
    tgt10 = PW'(target_q) * PW'(10);
    if (mode_q) rem_w = (target_q > words_q) ? PW'(target_q - words_q) : '0;
    else        rem_w = (tgt10 > PW'(elapsed_q)) ? tgt10 - PW'(elapsed_q) : '0;
    rem   = STAT_W'(rem_w);
    sum_w = PW'(good_q) + PW'(correct_q);
    wpm_w = (elapsed_q == '0) ? '0 : (sum_w * PW'(120)) / PW'(elapsed_q);
    acc_w = (keys_q == '0) ? '0 : (sum_w * PW'(100)) / PW'(keys_q);
    fin_cond = (elapsed_q == STAT_W'(LIMIT_TICKS)) || (!mode_q && rem == '0) ||
               (mode_q && words_q == target_q);
    exp_char = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      if (LW'(i) == cursor_q) exp_char = word[i*CODE_W +: CODE_W];
    full_word = (correct_q == word_len) && (cursor_q == word_len);
    good_sum  = GW'(good_q) + GW'(correct_q) + GW'(full_word);
    streak_n  = inc7(streak_q);
  end

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;         mode_d = mode_q;     target_d = target_q;
    typed_d = typed_q;   cursor_d = cursor_q;   correct_d = correct_q;
    words_d = words_q;   streak_d = streak_q;   best_d = best_q;
    elapsed_d = elapsed_q; keys_d = keys_q;     good_d = good_q;
    wpm_d = wpm_q;       acc_d = acc_q;         req_d = 1'b0;        fin_d = 1'b0;
    go_idle = 1'b0;      do_start = 1'b0;

    if (state_q == S_RUN) begin
      wpm_d = (wpm_w > PW'(999)) ? 10'd999 : wpm_w[9:0];
      acc_d = (acc_w > PW'(1023)) ? 10'd1023 : acc_w[9:0];
    end

    case (state_q)
      S_IDLE: do_start = start;
      S_CNTDN: begin
        if (abort) go_idle = 1'b1;
        else if (cnt_q == '0 || (tick && cnt_q == CW'(1))) begin
          state_d = S_RUN;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else if (tick) cnt_d = cnt_q - CW'(1);
      end
      S_RUN: begin
        if (abort) go_idle = 1'b1;
        else if (fin_cond) begin
          // keys and ticks in the finishing cycle are dropped
          state_d = S_DONE;
          fin_d   = 1'b1;
        end else if (pause) state_d = S_PAUSE;
        else begin
          if (tick && elapsed_q != STAT_W'(LIMIT_TICKS)) elapsed_d = elapsed_q + STAT_W'(1);
          if (key_valid) begin
            if (key_space) begin
              if (cursor_q != '0) begin
                keys_d    = (keys_q == '1) ? keys_q : keys_q + STAT_W'(1);
                good_d    = good_sum[GW-1] ? '1 : good_sum[STAT_W-1:0];
                words_d   = inc7(words_q);
                typed_d   = '0;
                cursor_d  = '0;
                correct_d = '0;
                req_d     = 1'b1;
                if (full_word) begin
                  streak_d = streak_n;
                  if (streak_n > best_q) best_d = streak_n;
                end else streak_d = '0;
              end
            end else if (key_back) begin
              if (cursor_q != '0) begin
                for (int unsigned i = 0; i < MAX_LEN; i++)
                  if (LW'(i + 1) == cursor_q) typed_d[i*CODE_W +: CODE_W] = '0;
                cursor_d = cursor_q - LW'(1);
                if (correct_q == cursor_q) correct_d = correct_q - LW'(1);
              end
            end else if (cursor_q < LW'(MAX_LEN)) begin
              for (int unsigned i = 0; i < MAX_LEN; i++)
                if (LW'(i) == cursor_q) typed_d[i*CODE_W +: CODE_W] = key_code;
              cursor_d = cursor_q + LW'(1);
              keys_d   = (keys_q == '1) ? keys_q : keys_q + STAT_W'(1);
              if (correct_q == cursor_q && cursor_q < word_len && key_code == exp_char)
                correct_d = correct_q + LW'(1);
            end
          end
        end
      end
      S_PAUSE: begin
        if (abort) go_idle = 1'b1;
        else if (pause) state_d = S_RUN;
      end
      S_DONE: begin
        if (abort) go_idle = 1'b1;
        else do_start = start;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle || do_start) begin
      state_d = S_IDLE;  cnt_d = '0;      mode_d = 1'b0;     target_d = '0;
      typed_d = '0;      cursor_d = '0;   correct_d = '0;    words_d = '0;
      streak_d = '0;     best_d = '0;     elapsed_d = '0;    keys_d = '0;
      good_d = '0;       wpm_d = '0;      acc_d = '0;        req_d = 1'b0;
      fin_d = 1'b0;
    end
    if (do_start) begin
      state_d  = S_CNTDN;
      cnt_d    = CW'(CNTDN_TICKS);
      mode_d   = mode;
      target_d = (target == '0) ? 7'd1 : target;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  cnt_q <= '0;      mode_q <= 1'b0;    target_q <= '0;
      typed_q <= '0;      cursor_q <= '0;   correct_q <= '0;   words_q <= '0;
      streak_q <= '0;     best_q <= '0;     elapsed_q <= '0;   keys_q <= '0;
      good_q <= '0;       wpm_q <= '0;      acc_q <= '0;       req_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;   cnt_q <= cnt_d;       mode_q <= mode_d;     target_q <= target_d;
      typed_q <= typed_d;   cursor_q <= cursor_d; correct_q <= correct_d; words_q <= words_d;
      streak_q <= streak_d; best_q <= best_d;     elapsed_q <= elapsed_d; keys_q <= keys_d;
      good_q <= good_d;     wpm_q <= wpm_d;       acc_q <= acc_d;       req_q <= req_d;
      fin_q <= fin_d;
    end
  end

  assign state       = state_q;
  assign typed       = typed_q;
  assign cursor      = cursor_q;
  assign correct     = correct_q;
  assign words_done  = words_q;
  assign elapsed     = elapsed_q;
  assign remaining   = rem;
  assign wpm         = wpm_q;
  assign acc         = acc_q;
  assign streak      = streak_q;
  assign best_streak = best_q;
  assign word_req    = req_q;
  assign finish      = fin_q;

endmodule
